axil_mem_slave: RTL and testbench



---
 rtl/axil_pkg.sv | 13 +
 rtl/axil_mem_slave_if.sv | 31 +++
 rtl/axil_byte_mem.sv | 24 ++
 rtl/axil_mem_slave.sv | 93 +++++++++
 tb/tb_axil_mem_slave.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// axil_pkg: shared response codes, read-state encoding and sizing helpers for the AXI4-Lite memory slave.
package axil_pkg;
  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  typedef enum logic {R_IDLE, R_VALID} rstate_t;
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction
  function automatic int idx_w(input int mem_bytes, input int data_w);
    return ($clog2(mem_bytes / (data_w / 8)) < 1) ? 1 : $clog2(mem_bytes / (data_w / 8));
  endfunction
endpackage

// File: rtl/axil_mem_slave_if.sv
// axil_mem_slave_if: AXI4-Lite write/read channel bundle with master and slave views.
interface axil_mem_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;
  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axil_byte_mem.sv
// axil_byte_mem: word array with per-byte write enables and a registered read port (read-before-write).
module axil_byte_mem import axil_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int MEM_BYTES = 64,
  localparam int SW = strb_w(DATA_W),
  localparam int IW = idx_w(MEM_BYTES, DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SW-1:0]     we,
  input  logic [IW-1:0]     widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IW-1:0]     ridx,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**IW];
  always_ff @(posedge clk)
    for (int i = 0; i < SW; i++)
      if (we[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[ridx];
endmodule

// File: rtl/axil_mem_slave.sv
// axil_mem_slave: AXI4-Lite memory slave, independent AW/W capture, one outstanding write, 1-cycle reads.
// AXIL_SLV_ERR_RESP_EN: out-of-range accesses answer SLVERR instead of wrapping.
module axil_mem_slave import axil_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MEM_BYTES = 64
) (
  input logic ACLK,
  input logic ARESET,
  axil_mem_slave_if.slave bus
);
  localparam int SW  = strb_w(DATA_W);
  localparam int IW  = idx_w(MEM_BYTES, DATA_W);
  localparam int LSB = $clog2(SW);
  logic              aw_held, w_held, awready, wready, bvalid, arready;
  logic              aw_held_n, w_held_n, bvalid_n, aw_hs, w_hs, ar_hs, commit;
  logic              aw_oob, ar_oob, aw_err_q;
  logic [IW-1:0]     awidx_q;
  logic [DATA_W-1:0] wdata_q, mem_rdata;
  logic [SW-1:0]     wstrb_q;
  resp_t             bresp, rresp;
  rstate_t           rstate, rstate_n;
  logic              addr_unused;
  assign addr_unused = ^{bus.AWADDR, bus.ARADDR};
`ifdef AXIL_SLV_ERR_RESP_EN
  assign aw_oob = (bus.AWADDR >> $clog2(MEM_BYTES)) != '0;
  assign ar_oob = (bus.ARADDR >> $clog2(MEM_BYTES)) != '0;
`else
  assign aw_oob = 1'b0;
  assign ar_oob = 1'b0;
`endif
  always_comb begin
    aw_hs     = bus.AWVALID && awready;
    w_hs      = bus.WVALID && wready;
    ar_hs     = bus.ARVALID && arready;
    commit    = aw_held && w_held;
    aw_held_n = !commit && (aw_held || aw_hs);
    w_held_n  = !commit && (w_held || w_hs);
    bvalid_n  = commit || (bvalid && !bus.BREADY);
    rstate_n  = ar_hs ? R_VALID : (rstate == R_VALID && bus.RREADY) ? R_IDLE : rstate;
  end
  // Readies are registered from next-state so they never assert while a response is pending.
  always_ff @(posedge ACLK or negedge ARESET)
    if (!ARESET) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rresp   <= RESP_OKAY;
    end else begin
      aw_held <= aw_held_n;
      w_held  <= w_held_n;
      awready <= !aw_held_n && !bvalid_n;
      wready  <= !w_held_n && !bvalid_n;
      bvalid  <= bvalid_n;
      if (commit) bresp <= aw_err_q ? RESP_SLVERR : RESP_OKAY;
      rstate  <= rstate_n;
      arready <= rstate_n == R_IDLE;
      if (ar_hs) rresp <= ar_oob ? RESP_SLVERR : RESP_OKAY;
    end
  always_ff @(posedge ACLK) begin
    if (aw_hs) begin
      awidx_q  <= IW'(bus.AWADDR >> LSB);
      aw_err_q <= aw_oob;
    end
    if (w_hs) begin
      wdata_q <= bus.WDATA;
      wstrb_q <= bus.WSTRB;
    end
  end
  axil_byte_mem #(.DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) u_mem (
    .clk   (ACLK),
    .rst_n (ARESET),
    .we    ((commit && !aw_err_q) ? wstrb_q : '0),
    .widx  (awidx_q),
    .wdata (wdata_q),
    .re    (ar_hs),
    .ridx  (IW'(bus.ARADDR >> LSB)),
    .rdata (mem_rdata)
  );
  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.BVALID  = bvalid;
  assign bus.BRESP   = bresp;
  assign bus.ARREADY = arready;
  assign bus.RVALID  = rstate == R_VALID;
  assign bus.RRESP   = rresp;
  assign bus.RDATA   = (rresp == RESP_SLVERR) ? '0 : mem_rdata;
endmodule

// File: tb/tb_axil_mem_slave.sv
// tb_axil_mem_slave: directed scenario bench for axil_mem_slave (32-bit data, 64-byte memory).
module tb_axil_mem_slave;
  logic ACLK = 1'b0;
  logic ARESET = 1'b0;
  int checks = 0;
  int errors = 0;
  axil_mem_slave_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  axil_mem_slave #(.DATA_W(32), .ADDR_W(32), .MEM_BYTES(64)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    int n = 0;
    while (!(bus.AWREADY && bus.WREADY) && n < 20) begin tick(); n++; end
    bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    n = 0;
    while (!bus.BVALID && n < 20) begin tick(); n++; end
    checks++;
    if (bus.BVALID !== 1'b1) begin
      errors++;
      $display("FAIL wr_timeout addr=%h bvalid=%b required 1", a, bus.BVALID);
    end
    resp = bus.BRESP;
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    while (!bus.ARREADY && n < 20) begin tick(); n++; end
    bus.ARADDR = a; bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    n = 0;
    while (!bus.RVALID && n < 20) begin tick(); n++; end
    checks++;
    if (bus.RVALID !== 1'b1) begin
      errors++;
      $display("FAIL rd_timeout addr=%h rvalid=%b required 1", a, bus.RVALID);
    end
    d = bus.RDATA;
    resp = bus.RRESP;
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b0;
    tick(); tick();
    checks++;
    if ({bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b required 00000", {bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID});
    end
    checks++;
    if ({bus.RDATA, bus.BRESP, bus.RRESP} !== 36'h0) begin
      errors++;
      $display("FAIL reset_data got=%h required 0", {bus.RDATA, bus.BRESP, bus.RRESP});
    end
    ARESET = 1'b1;
    tick();
    checks++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready got=%b required 111", {bus.AWREADY, bus.WREADY, bus.ARREADY});
    end
  endtask

  task automatic test_same_cycle();
    bus.AWADDR = 32'h04; bus.WDATA = 32'hDEADBEEF; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    checks++;
    if ({bus.AWREADY, bus.WREADY, bus.BVALID} !== 3'b000) begin
      errors++;
      $display("FAIL same_hs got aw/w/b=%b required 000", {bus.AWREADY, bus.WREADY, bus.BVALID});
    end
    tick();
    checks++;
    if ({bus.BVALID, bus.BRESP} !== 3'b100) begin
      errors++;
      $display("FAIL same_commit got bvalid/bresp=%b required 100", {bus.BVALID, bus.BRESP});
    end
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    checks++;
    if ({bus.BVALID, bus.AWREADY, bus.WREADY} !== 3'b011) begin
      errors++;
      $display("FAIL same_bdone got b/aw/w=%b required 011", {bus.BVALID, bus.AWREADY, bus.WREADY});
    end
    bus.ARADDR = 32'h04; bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    checks++;
    if ({bus.RVALID, bus.ARREADY, bus.RDATA} !== {2'b10, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL same_read got rvalid=%b arready=%b rdata=%h required 1 0 deadbeef", bus.RVALID, bus.ARREADY, bus.RDATA);
    end
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r;
    logic [31:0] d;
    wr(32'h08, 32'hFFFFFFFF, 4'hF, r);
    bus.WDATA = 32'h11223344; bus.WSTRB = 4'h5; bus.WVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    checks++;
    if ({bus.WREADY, bus.AWREADY, bus.BVALID} !== 3'b010) begin
      errors++;
      $display("FAIL wfirst_hold got w/aw/b=%b required 010", {bus.WREADY, bus.AWREADY, bus.BVALID});
    end
    tick(); tick();
    checks++;
    if (bus.BVALID !== 1'b0) begin
      errors++;
      $display("FAIL wfirst_no_b got bvalid=%b required 0", bus.BVALID);
    end
    bus.AWADDR = 32'h08; bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    tick();
    checks++;
    if ({bus.BVALID, bus.BRESP} !== 3'b100) begin
      errors++;
      $display("FAIL wfirst_commit got bvalid/bresp=%b required 100", {bus.BVALID, bus.BRESP});
    end
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    rd(32'h08, d, r);
    checks++;
    if (d !== 32'hFF22FF44) begin
      errors++;
      $display("FAIL wfirst_strobe got=%h required ff22ff44", d);
    end
  endtask

  task automatic test_bready_stall();
    logic [1:0] r;
    logic [31:0] d;
    bus.AWADDR = 32'h0C; bus.WDATA = 32'h0C0C0C0C; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    tick();
    bus.AWADDR = 32'h14; bus.WDATA = 32'h99; bus.WSTRB = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY} !== 5'b10000) begin
        errors++;
        $display("FAIL bstall_%0d got b/resp/aw/w=%b required 10000", i, {bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY});
      end
    end
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    checks++;
    if ({bus.BVALID, bus.AWREADY, bus.WREADY} !== 3'b011) begin
      errors++;
      $display("FAIL bstall_release got b/aw/w=%b required 011", {bus.BVALID, bus.AWREADY, bus.WREADY});
    end
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    checks++;
    if ({bus.AWREADY, bus.WREADY} !== 2'b00) begin
      errors++;
      $display("FAIL bstall_second_hs got aw/w=%b required 00", {bus.AWREADY, bus.WREADY});
    end
    tick();
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    rd(32'h14, d, r);
    checks++;
    if (d !== 32'h99) begin
      errors++;
      $display("FAIL bstall_second_data got=%h required 00000099", d);
    end
  endtask

  task automatic test_rready_stall();
    bus.ARADDR = 32'h0C; bus.ARVALID = 1'b1;
    tick();
    bus.ARADDR = 32'h14;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.RVALID, bus.ARREADY, bus.RDATA, bus.RRESP} !== {2'b10, 32'h0C0C0C0C, 2'b00}) begin
        errors++;
        $display("FAIL rstall_%0d got rvalid=%b arready=%b rdata=%h required 1 0 0c0c0c0c", i, bus.RVALID, bus.ARREADY, bus.RDATA);
      end
      tick();
    end
    bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    checks++;
    if ({bus.RVALID, bus.ARREADY} !== 2'b01) begin
      errors++;
      $display("FAIL rstall_release got rvalid/arready=%b required 01", {bus.RVALID, bus.ARREADY});
    end
  endtask

  task automatic test_read_before_write();
    logic [1:0] r;
    logic [31:0] d;
    wr(32'h10, 32'h55555555, 4'hF, r);
    bus.AWADDR = 32'h10; bus.WDATA = 32'hAAAAAAAA; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.ARADDR = 32'h10; bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    checks++;
    if ({bus.BVALID, bus.RVALID, bus.RDATA} !== {2'b11, 32'h55555555}) begin
      errors++;
      $display("FAIL rbw_old got b=%b r=%b rdata=%h required 1 1 55555555", bus.BVALID, bus.RVALID, bus.RDATA);
    end
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    rd(32'h10, d, r);
    checks++;
    if (d !== 32'hAAAAAAAA) begin
      errors++;
      $display("FAIL rbw_new got=%h required aaaaaaaa", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r;
    logic [31:0] d;
    wr(32'h00, 32'h12345678, 4'hF, r);
    wr(32'h40, 32'hCAFEF00D, 4'hF, r);
`ifdef AXIL_SLV_ERR_RESP_EN
    checks++;
    if (r !== 2'b10) begin
      errors++;
      $display("FAIL oob_bresp got=%b required 10", r);
    end
    rd(32'h00, d, r);
    checks++;
    if ({d, r} !== {32'h12345678, 2'b00}) begin
      errors++;
      $display("FAIL oob_mem_kept got=%h resp=%b required 12345678 00", d, r);
    end
    rd(32'h40, d, r);
    checks++;
    if ({d, r} !== {32'h0, 2'b10}) begin
      errors++;
      $display("FAIL oob_read got=%h resp=%b required 00000000 10", d, r);
    end
`else
    checks++;
    if (r !== 2'b00) begin
      errors++;
      $display("FAIL wrap_bresp got=%b required 00", r);
    end
    rd(32'h00, d, r);
    checks++;
    if ({d, r} !== {32'hCAFEF00D, 2'b00}) begin
      errors++;
      $display("FAIL wrap_mem got=%h resp=%b required cafef00d 00", d, r);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [1:0] r;
    logic [31:0] d;
    bus.AWADDR = 32'h18; bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    ARESET = 1'b0;
    tick();
    ARESET = 1'b1;
    tick();
    checks++;
    if ({bus.AWREADY, bus.WREADY, bus.BVALID} !== 3'b110) begin
      errors++;
      $display("FAIL rstmid_ready got aw/w/b=%b required 110", {bus.AWREADY, bus.WREADY, bus.BVALID});
    end
    bus.WDATA = 32'h77777777; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.BVALID !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_no_b_%0d got bvalid=%b required 0", i, bus.BVALID);
      end
    end
    rd(32'h10, d, r);
    checks++;
    if (d !== 32'hAAAAAAAA) begin
      errors++;
      $display("FAIL rstmid_mem_kept got=%h required aaaaaaaa", d);
    end
  endtask

  initial begin
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_bready_stall();
    test_rready_stall();
    test_read_before_write();
    test_out_of_range();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
